// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port 1RW SRAM initiator controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;

    function automatic int cnt_width(input int read_lat);
        return (read_lat < 1) ? 1 : $clog2(read_lat + 1);
    endfunction

endpackage

// File: rtl/sram_1rw_ctrl_if.sv
// Request/response valid-ready bundle between a bus agent (master) and the SRAM controller (slave).
interface sram_1rw_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_is_wr;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_is_wr
    );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// Sequences SRAM CSb/WEb/OEb/DATA pins from a valid/ready request stream and returns read data.
// Optional write acknowledge responses are enabled by defining SRAM_CTRL_WRACK_EN.
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    sram_1rw_ctrl_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    localparam int CW = cnt_width(READ_LAT);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic                  oeb_q, oeb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef SRAM_CTRL_WRACK_EN
    logic                  is_wr_q, is_wr_d;
`endif

    // Next-state and registered pin values; pins are set for the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        csb_d       = CSB_IDLE;
        web_d       = WEB_IDLE;
        oeb_d       = OEB_IDLE;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
`ifdef SRAM_CTRL_WRACK_EN
        is_wr_d     = is_wr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    csb_d  = 1'b0;
                    if (bus.req_we) begin
                        wdata_d = bus.req_wdata;
                        web_d   = 1'b0;
                        state_d = WR;
                    end else begin
                        cnt_d   = CW'(READ_LAT);
                        oeb_d   = 1'b0;
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
`ifdef SRAM_CTRL_WRACK_EN
                rsp_valid_d = 1'b1;
                rdata_d     = {DATA_WIDTH{1'b0}};
                is_wr_d     = 1'b1;
                state_d     = RESP;
`else
                state_d     = IDLE;
`endif
            end
            RD: begin
                // Re-reading the held address while the counter drains is harmless.
                if (cnt_q == {CW{1'b0}}) begin
                    rdata_d     = sram_data;
                    rsp_valid_d = 1'b1;
`ifdef SRAM_CTRL_WRACK_EN
                    is_wr_d     = 1'b0;
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    csb_d = 1'b0;
                    oeb_d = 1'b0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            addr_q      <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            csb_q       <= CSB_IDLE;
            web_q       <= WEB_IDLE;
            oeb_q       <= OEB_IDLE;
            rsp_valid_q <= 1'b0;
            rdata_q     <= {DATA_WIDTH{1'b0}};
`ifdef SRAM_CTRL_WRACK_EN
            is_wr_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
`ifdef SRAM_CTRL_WRACK_EN
            is_wr_q     <= is_wr_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
`ifdef SRAM_CTRL_WRACK_EN
    assign bus.rsp_is_wr = is_wr_q;
`else
    assign bus.rsp_is_wr = 1'b0;
`endif

    assign sram_addr = addr_q;
    assign sram_csb  = csb_q;
    assign sram_web  = web_q;
    assign sram_oeb  = oeb_q;
    assign sram_data = (state_q == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Randomized scoreboard bench for sram_1rw_ctrl with a behavioural SRAM and reference memory.
module tb_sram_1rw_ctrl;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clk;
    logic          rstb;
    logic [AW-1:0] sram_addr;
    logic          sram_csb;
    logic          sram_web;
    logic          sram_oeb;
    wire  [DW-1:0] sram_data;

    sram_1rw_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LAT(1)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_data (sram_data)
    );

    // SRAM macro model: samples on the edge, drives the bus while OEb is low
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] sram_dout;
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) sram_mem[sram_addr] <= sram_data;
            else           sram_dout <= sram_mem[sram_addr];
        end
    end
    assign sram_data = (!sram_csb && !sram_oeb) ? sram_dout : {DW{1'bz}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          is_wr;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            n_cmp = 0;
    int            n_err = 0;
    int            rr_mode = 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // rsp_ready driver: 0 = random, 1 = always ready, 2 = stalled
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.rsp_ready = 1'($urandom_range(0, 1));
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops on response handshakes, stall stability and bus turnaround
    logic          stall_v = 1'b0;
    logic [DW-1:0] stall_rdata;
    logic          stall_is_wr;
    logic          prev_oeb = 1'b1;
    always @(negedge clk) begin
        if (!rstb) begin
            stall_v  = 1'b0;
            prev_oeb = 1'b1;
        end else begin
            if (!sram_web) chk("turnaround_oeb", {62'd0, prev_oeb, sram_oeb}, 64'd3);
            prev_oeb = sram_oeb;
            if (bus.rsp_valid && stall_v) begin
                chk("stall_rdata", {32'd0, bus.rsp_rdata}, {32'd0, stall_rdata});
                chk("stall_is_wr", {63'd0, bus.rsp_is_wr}, {63'd0, stall_is_wr});
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rdata 0x%0h with no response expected at %0t",
                             bus.rsp_rdata, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e.rdata});
                    chk("rsp_is_wr", {63'd0, bus.rsp_is_wr}, {63'd0, e.is_wr});
                end
            end
            stall_v     = bus.rsp_valid && !bus.rsp_ready;
            stall_rdata = bus.rsp_rdata;
            stall_is_wr = bus.rsp_is_wr;
        end
    end

    // Present one request, hold it until accepted, and record what the reference expects back
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("req_accept_timeout", 64'd0, 64'd1);
        end else if (we) begin
            ref_mem[a] = d;
`ifdef SRAM_CTRL_WRACK_EN
            e.rdata = '0;
            e.is_wr = 1'b1;
            sb.push_back(e);
`endif
        end else begin
            e.rdata = ref_mem[a];
            e.is_wr = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_dout     = '0;
        rstb          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_csb", {63'd0, sram_csb}, 64'd1);
        chk("rst_oeb_web", {62'd0, sram_oeb, sram_web}, 64'd3);
        chk("rst_addr", {53'd0, sram_addr}, 64'd0);
        chk("rst_rsp", {31'd0, bus.rsp_valid, bus.rsp_rdata}, 64'd0);
        rstb = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // Write 0x005: one active WR cycle
        issue(1'b1, 11'h005, 32'hDEADBEEF);
        chk("wr_pins", {61'd0, sram_csb, sram_web, sram_oeb}, 64'd1);
        chk("wr_bus", {32'd0, sram_data}, 64'h0000_0000_DEAD_BEEF);
        chk("wr_req_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("wr_done_csb", {63'd0, sram_csb}, 64'd1);
`ifdef SRAM_CTRL_WRACK_EN
        chk("wrack_valid", {63'd0, bus.rsp_valid}, 64'd1);
`else
        chk("wr_done_ready", {63'd0, bus.req_ready}, 64'd1);
`endif
        drain();

        // Read 0x005 with READ_LAT=1: OEb low for two cycles, response after the third edge
        issue(1'b0, 11'h005, 32'd0);
        chk("rd_c1_pins", {61'd0, sram_csb, sram_web, sram_oeb}, 64'd2);
        @(posedge clk); #1;
        chk("rd_c2_oeb", {63'd0, sram_oeb}, 64'd0);
        chk("rd_c2_valid", {63'd0, bus.rsp_valid}, 64'd0);
        @(posedge clk); #1;
        chk("rd_resp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("rd_resp_oeb", {63'd0, sram_oeb}, 64'd1);
        drain();

        // Stalled response for 10 cycles
        rr_mode = 2;
        issue(1'b0, 11'h005, 32'd0);
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) begin
            @(posedge clk); #2;
        end
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
            @(posedge clk); #2;
        end
        rr_mode = 1;
        drain();
        @(posedge clk); #2;
        chk("stall_released", {63'd0, bus.rsp_valid}, 64'd0);

        // Read 0x7FF, immediate write, reread
        issue(1'b0, 11'h7FF, 32'd0);
        issue(1'b1, 11'h7FF, 32'h12345678);
        issue(1'b0, 11'h7FF, 32'd0);
        drain();

        // Reset during the second RD cycle aborts the read
        issue(1'b0, 11'h005, 32'd0);
        @(posedge clk); #2;
        rstb = 1'b0;
        #1;
        chk("abort_pins", {60'd0, sram_csb, sram_web, sram_oeb, bus.rsp_valid}, 64'd14);
        sb.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        issue(1'b0, 11'h005, 32'd0);
        drain();

        // Write 0x010: ack only in the WRACK build
        issue(1'b1, 11'h010, 32'hA5A5A5A5);
`ifndef SRAM_CTRL_WRACK_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_wrack", {63'd0, bus.rsp_valid}, 64'd0);
        end
`endif
        drain();

        // Randomized mix against the reference memory
        rr_mode = 0;
        for (int i = 0; i < 200; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rr_mode = 1;
        drain();
        issue(1'b0, 11'h010, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_1rw_ctrl.md
Name: sram_1rw_ctrl

Overview:
Initiator-side controller for the single-port 1RW SRAM macro (CSb/WEb/OEb, shared bidirectional DATA bus). Converts a valid/ready request stream (read or write) into correctly sequenced SRAM pin activity and returns read data on a valid/ready response channel. Sits between a bus agent or BIST engine and one SRAM instance. Owns bus turnaround and read-capture timing.

Parameters:
DATA_WIDTH, 32, data word width; matches SRAM DATA.
ADDR_WIDTH, 11, address width; matches SRAM ADDR.
READ_LAT, 1, cycles from the SRAM read-sample edge to the capture edge; min 1; needs clock period > SRAM output delay.

Ports:
clk  input  1  clock; all state updates on posedge.
rstb  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  word address.
req_wdata  input  DATA_WIDTH  write data.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  DATA_WIDTH  read data; 0 for write acks.
rsp_is_wr  output  1  response is a write ack; 0 unless SRAM_CTRL_WRACK_EN.
sram_addr  output  ADDR_WIDTH  to SRAM ADDR.
sram_csb  output  1  to SRAM CSb, active low.
sram_web  output  1  to SRAM WEb, active low.
sram_oeb  output  1  to SRAM OEb, active low.
sram_data  inout  DATA_WIDTH  to SRAM DATA; driven only in WR, else high-Z.

Behaviour:
- Reset (async assert, sync release): state IDLE; sram_csb=1, sram_web=1, sram_oeb=1, sram_addr=0, sram_data=Z; rsp_valid=0, rsp_rdata=0, rsp_is_wr=0; internal addr/wdata/counter regs cleared. Reset asserted mid-read or mid-write aborts immediately; no response is produced.
- SRAM pin outputs come from registers; no combinational path from req_* to sram_*.
- req_ready = (state==IDLE), combinational from state. Handshake = req_valid & req_ready at posedge; addr/we/wdata are registered at that edge.
- States:
  IDLE: pins idle (csb=web=oeb=1, bus Z). Handshake with we=1 -> WR; with we=0 -> RD, counter loaded with READ_LAT.
  WR: exactly 1 cycle; csb=0, web=0, oeb=1, sram_data driven with wdata. SRAM writes at the edge that ends WR. Next state is IDLE, or RESP when SRAM_CTRL_WRACK_EN is defined.
  RD: lasts 1+READ_LAT cycles; csb=0, web=1, oeb=0, sram_addr held, bus Z. The first edge is the SRAM read sample; later edges re-read the same address, which is harmless. The counter decrements each edge after the first. At the last edge (counter==0), sram_data is captured into rsp_rdata and the state moves to RESP.
  RESP: rsp_valid=1; pins idle. rsp_valid & rsp_ready at posedge -> IDLE. rsp_rdata and rsp_is_wr stay stable while rsp_valid=1 and rsp_ready=0, for unbounded stall.
- Latency, with accept edge E0: write pins active E0..E1. Read pins active E0..E(1+READ_LAT); with READ_LAT=1, rsp_valid rises after E2.
- Throughput: one write per 2 cycles; one read per READ_LAT+3 cycles at full rsp_ready.
- Turnaround: IDLE always separates a read and a following write, so oeb=1 for at least 1 cycle before the controller drives the bus. The controller and SRAM never drive sram_data in the same cycle.
- req_valid while not IDLE: ignored, no handshake; the requester holds its request.
- rsp_ready while rsp_valid=0: ignored.
- Captured X/Z bits pass through unchanged; no checking.

Optional Feature:
SRAM_CTRL_WRACK_EN. Defined: WR -> RESP with rsp_valid=1, rsp_is_wr=1, rsp_rdata=0; writes then obey the rsp_ready backpressure rules. Undefined: WR -> IDLE, writes produce no response, and rsp_is_wr is tied to 0.

Decomposition:
Package sram_ctrl_pkg holds:
- the state enum (IDLE, WR, RD, RESP);
- the pin idle constants (CSB_IDLE=1, WEB_IDLE=1, OEB_IDLE=1);
- the counter width function, $clog2(READ_LAT+1).
Single module; no sub-module is warranted. The tri-state driver is one continuous assign gated by state==WR.

Test Plan:
- Reset, then write addr 0x005 data 0xDEADBEEF -> one WR cycle with csb=0, web=0, bus=0xDEADBEEF; req_ready=0 for exactly that cycle.
- Read addr 0x005 after that write, rsp_ready=1, READ_LAT=1 -> rsp_valid after the 3rd edge from accept, rsp_rdata=0xDEADBEEF, oeb=0 for 2 cycles.
- Read with rsp_ready=0 for 10 cycles -> rsp_valid stays 1, rdata stable, req_ready=0 throughout; accepted on the 11th cycle.
- Read 0x7FF then immediate write 0x7FF=0x12345678 -> at least 1 cycle with oeb=1 and bus Z between them; no X contention on sram_data; a reread returns 0x12345678.
- rstb low during the 2nd RD cycle -> pins idle and bus Z immediately (async); no rsp_valid; next request after release completes normally.
- WRACK_EN build: write 0x010=0xA5A5A5A5 -> rsp_valid=1, rsp_is_wr=1, rsp_rdata=0. Non-WRACK build: same write -> rsp_valid stays 0.
